// File: rtl/ser_frame_aligner.sv
// Multi-lane serial deserialiser: word-aligns every lane on the lane-0 idle pattern,
// classifies lane-0 words and tracks lock quality with saturating frame/error counters.
module ser_frame_aligner #(
  parameter int unsigned       N_LANES   = 4,
  parameter int unsigned       WORD_W    = 32,
  parameter int unsigned       PAT_W     = 8,
  parameter logic [PAT_W-1:0]  PAT_DTU   = 8'b00110101,
  parameter logic [PAT_W-1:0]  PAT_ATM   = 8'b01011010,
  parameter int unsigned       ERR_LIMIT = 4,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                      clk_srl,
  input  logic                      rst,
  input  logic                      test_enable,
  input  logic                      cal_busy,
  input  logic [N_LANES-1:0]        ser_in,
  output logic                      aligned,
  output logic                      word_valid,
  output logic [N_LANES*WORD_W-1:0] word_o,
  output logic [3:0]                word_type,
  output logic [2:0]                n_samples,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int unsigned IdxW = $clog2(WORD_W);
  localparam int unsigned ErrW = $clog2(ERR_LIMIT + 1);
  localparam logic [IdxW-1:0] IdxTop   = IdxW'(WORD_W - 1);
  localparam logic [IdxW-1:0] IdxLoad  = IdxW'(WORD_W - PAT_W - 1);
  localparam logic [ErrW-1:0] ErrLimit = ErrW'(ERR_LIMIT);

  localparam logic [1:0] StHunt    = 2'd0;
  localparam logic [1:0] StConfirm = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  localparam logic [3:0] TyRaw  = 4'd0;
  localparam logic [3:0] TyBl5  = 4'd1;
  localparam logic [3:0] TyBln  = 4'd2;
  localparam logic [3:0] TySig2 = 4'd3;
  localparam logic [3:0] TySig1 = 4'd4;
  localparam logic [3:0] TyHdr  = 4'd5;
  localparam logic [3:0] TyIdle = 4'd6;
  localparam logic [3:0] TyRst  = 4'd7;
  localparam logic [3:0] TyTrl  = 4'd8;
  localparam logic [3:0] TyErr  = 4'd9;

  logic [1:0]                          state_q, state_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  logic                                te_q;
  logic [ErrW-1:0]                     err_run_q, err_run_d, err_run_inc;
  // Only PAT_W-1 history bits are stored; the live bit completes the compare window.
  logic [N_LANES-1:0][PAT_W-2:0]       sh_q;
  logic [N_LANES-1:0][PAT_W-1:0]       sh_d;
  logic [N_LANES-1:0][WORD_W-1:0]      acc_q, acc_d;
  logic                                valid_q, valid_d;
  logic [N_LANES-1:0][WORD_W-1:0]      word_q, word_d;
  logic [3:0]                          type_q, type_d;
  logic [2:0]                          nsamp_q, nsamp_d;
  logic [CNT_W-1:0]                    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]                    err_cnt_q, err_cnt_d;
  logic [PAT_W-1:0]                    pattern;
  logic [3:0]                          cls_type;
  logic [2:0]                          cls_n;
  logic [2:0]                          bln_n;

  assign pattern = test_enable ? PAT_ATM : PAT_DTU;

  always_comb begin
    sh_d  = '0;
    acc_d = acc_q;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      sh_d[k] = {sh_q[k], ser_in[k]};
      if (state_q == StHunt) begin
        acc_d[k][WORD_W-1 -: PAT_W] = sh_d[k];
      end else begin
        acc_d[k][idx_q] = ser_in[k];
      end
    end
  end

  // Lane-0 decode; fields are located relative to the word MSB.
  always_comb begin
    cls_type = TyErr;
    cls_n    = 3'd0;
    bln_n    = acc_d[0][WORD_W-6 -: 3];
    if (test_enable || cal_busy) begin
      cls_type = TyRaw;
    end else if (acc_d[0][WORD_W-1 -: 2] == 2'b01) begin
      cls_type = TyBl5;
      cls_n    = 3'd5;
    end else if (acc_d[0][WORD_W-1 -: 2] == 2'b10) begin
      if (bln_n != 3'd0 && bln_n <= 3'd4) begin
        cls_type = TyBln;
        cls_n    = bln_n;
      end
    end else if (acc_d[0][WORD_W-1 -: 6] == 6'b001010) begin
      cls_type = TySig2;
      cls_n    = 3'd2;
    end else if (acc_d[0][WORD_W-1 -: 7] == 7'b0010110) begin
      cls_type = TySig1;
      cls_n    = 3'd1;
    end else if (acc_d[0][WORD_W-1 -: 7] == 7'b0010111) begin
      cls_type = TyHdr;
      cls_n    = 3'd1;
    end else if (acc_d[0][WORD_W-1 -: 4] == 4'b1110) begin
      cls_type = TyIdle;
    end else if (acc_d[0][WORD_W-1 -: 6] == 6'b001101) begin
      cls_type = TyRst;
    end else if (acc_d[0][WORD_W-1 -: 4] == 4'b1101) begin
      cls_type = TyTrl;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_run_d   = err_run_q;
    valid_d     = 1'b0;
    word_d      = word_q;
    type_d      = type_q;
    nsamp_d     = nsamp_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_run_inc = err_run_q + ErrW'(1);
    if (state_q != StHunt && test_enable != te_q) begin
      // Mode change: drop the partial word without a strobe.
      state_d   = StHunt;
      err_run_d = '0;
    end else if (state_q == StHunt) begin
      if (sh_d[0] == pattern) begin
        state_d = StConfirm;
        idx_d   = IdxLoad;
      end
    end else begin
      idx_d = idx_q - IdxW'(1);
      if (idx_q == '0) begin
        idx_d   = IdxTop;
        valid_d = 1'b1;
        word_d  = acc_d;
        type_d  = cls_type;
        nsamp_d = cls_n;
        if (cls_type == TyErr && err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (state_q == StConfirm) begin
          state_d   = (cls_type == TyErr) ? StHunt : StLocked;
          err_run_d = '0;
        end else if (cls_type == TyErr) begin
          if (err_run_inc >= ErrLimit) begin
            state_d   = StHunt;
            err_run_d = '0;
          end else begin
            err_run_d = err_run_inc;
          end
        end else begin
          err_run_d = '0;
          if (cls_type == TyTrl && frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_srl) begin
    if (rst) begin
      state_q     <= StHunt;
      idx_q       <= '0;
      te_q        <= 1'b0;
      err_run_q   <= '0;
      sh_q        <= '0;
      acc_q       <= '0;
      valid_q     <= 1'b0;
      word_q      <= '0;
      type_q      <= TyRaw;
      nsamp_q     <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      te_q        <= test_enable;
      err_run_q   <= err_run_d;
      for (int unsigned k = 0; k < N_LANES; k++) begin
        sh_q[k] <= sh_d[k][PAT_W-2:0];
      end
      acc_q       <= acc_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
      type_q      <= type_d;
      nsamp_q     <= nsamp_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign aligned    = (state_q == StLocked);
  assign word_valid = valid_q;
  assign word_o     = word_q;
  assign word_type  = type_q;
  assign n_samples  = nsamp_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ser_frame_aligner.sv
// Randomised bench for ser_frame_aligner against a stream-history reference model.
module tb_ser_frame_aligner;

  localparam int NL      = 4;
  localparam int WW      = 32;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;
  localparam int PH_HUNT = 0;
  localparam int PH_CONF = 1;
  localparam int PH_LOCK = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              test_enable = 1'b0;
  logic              cal_busy = 1'b0;
  logic [NL-1:0]     ser_in = '0;
  logic              aligned;
  logic              word_valid;
  logic [NL*WW-1:0]  word_o;
  logic [3:0]        word_type;
  logic [2:0]        n_samples;
  logic [CW-1:0]     frame_cnt;
  logic [CW-1:0]     err_cnt;

  ser_frame_aligner #(
    .N_LANES(NL),
    .WORD_W (WW),
    .CNT_W  (CW)
  ) u_dut (
    .clk_srl    (clk),
    .rst        (rst),
    .test_enable(test_enable),
    .cal_busy   (cal_busy),
    .ser_in     (ser_in),
    .aligned    (aligned),
    .word_valid (word_valid),
    .word_o     (word_o),
    .word_type  (word_type),
    .n_samples  (n_samples),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: last 64 bits of each lane plus the alignment phase.
  logic [63:0]      hist [NL];
  int               phase, left, run, m_frames, m_errs;
  logic             m_prev_te;
  logic             exp_valid;
  logic [NL*WW-1:0] exp_word;
  int               exp_type, exp_n;
  logic [31:0]      last_lane1;

  logic [31:0] pre [9] = '{32'h4000_0000, 32'h8000_0000, 32'h2800_0000, 32'h2C00_0000,
                           32'h2E00_0000, 32'hE000_0000, 32'h3400_0000, 32'hD000_0000,
                           32'h0000_0000};
  logic [31:0] msk [9] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h03FF_FFFF, 32'h01FF_FFFF,
                           32'h01FF_FFFF, 32'h0FFF_FFFF, 32'h03FF_FFFF, 32'h0FFF_FFFF,
                           32'hFFFF_FFFF};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void classify(input logic [31:0] w, input logic raw,
                                   output int t, output int n);
    t = 9;
    n = 0;
    if (raw) begin
      t = 0;
    end else begin
      casez (w[31:24])
        8'b01??????: begin t = 1; n = 5; end
        8'b10??????: begin
          n = int'(w[26:24]);
          if (n == 0 || n > 4) begin t = 9; n = 0; end
          else t = 2;
        end
        8'b001010??: begin t = 3; n = 2; end
        8'b0010110?: begin t = 4; n = 1; end
        8'b0010111?: begin t = 5; n = 1; end
        8'b1110????: t = 6;
        8'b001101??: t = 7;
        8'b1101????: t = 8;
        default:     t = 9;
      endcase
    end
  endfunction

  task automatic model_step();
    int t, n;
    logic [7:0] pat;
    exp_valid = 1'b0;
    if (rst) begin
      for (int k = 0; k < NL; k++) hist[k] = '0;
      phase    = PH_HUNT;
      run      = 0;
      m_frames = 0;
      m_errs   = 0;
      exp_word = '0;
      exp_type = 0;
      exp_n    = 0;
    end else begin
      for (int k = 0; k < NL; k++) hist[k] = {hist[k][62:0], ser_in[k]};
      pat = test_enable ? 8'h5A : 8'h35;
      if (phase != PH_HUNT && test_enable != m_prev_te) begin
        phase = PH_HUNT;
        run   = 0;
      end else if (phase == PH_HUNT) begin
        if (hist[0][7:0] == pat) begin
          phase = PH_CONF;
          left  = WW - 8;
        end
      end else begin
        left--;
        if (left == 0) begin
          left = WW;
          for (int k = 0; k < NL; k++) exp_word[k*WW +: WW] = hist[k][31:0];
          classify(hist[0][31:0], test_enable | cal_busy, t, n);
          exp_type  = t;
          exp_n     = n;
          exp_valid = 1'b1;
          if (t == 9 && m_errs < CMAX) m_errs++;
          if (phase == PH_CONF) begin
            phase = (t == 9) ? PH_HUNT : PH_LOCK;
            run   = 0;
          end else if (t == 9) begin
            run++;
            if (run >= 4) begin
              phase = PH_HUNT;
              run   = 0;
            end
          end else begin
            run = 0;
            if (t == 8 && m_frames < CMAX) m_frames++;
          end
        end
      end
    end
    m_prev_te = test_enable;
  endtask

  // Drive at negedge, let the DUT take the edge, compare at the following negedge.
  task automatic step(input logic [NL-1:0] bits);
    ser_in = bits;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("word_valid", 128'(word_valid), 128'(exp_valid));
    check_eq("aligned", 128'(aligned), 128'(phase == PH_LOCK));
    check_eq("frame_cnt", 128'(frame_cnt), 128'(m_frames));
    check_eq("err_cnt", 128'(err_cnt), 128'(m_errs));
    if (exp_valid || rst) begin
      check_eq("word_o", 128'(word_o), 128'(exp_word));
      check_eq("word_type", 128'(word_type), 128'(exp_type));
      check_eq("n_samples", 128'(n_samples), 128'(exp_n));
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [2:0] r;
    for (int b = WW - 1; b >= 0; b--) begin
      r = 3'($urandom);
      last_lane1 = {last_lane1[30:0], r[0]};
      step({r, w[b]});
    end
  endtask

  task automatic send_bits(input int count, input logic lane0_rand);
    for (int i = 0; i < count; i++) begin
      step({3'($urandom), lane0_rand ? 1'($urandom) : 1'b0});
    end
  endtask

  int          kind;
  logic [31:0] w;

  initial begin
    @(negedge clk);
    repeat (3) step('0);
    check_eq("rst_word_o", 128'(word_o), 128'(0));
    check_eq("rst_aligned", 128'(aligned), 128'(0));
    rst = 1'b0;

    // Lock on the DTU idle pattern, then steady IDLE words.
    send_bits(5, 1'b0);
    send_word({8'h35, 24'($urandom)});
    check_eq("s1_strobe", 128'(word_valid), 128'(1));
    check_eq("s1_aligned", 128'(aligned), 128'(1));
    check_eq("s1_lane1", 128'(word_o[63:32]), 128'(last_lane1));
    repeat (3) begin
      send_word(32'hE000_0000);
      check_eq("s1_idle", 128'(word_type), 128'(6));
    end

    send_word(32'h2C00_1ABC);
    check_eq("s2_type", 128'(word_type), 128'(4));
    check_eq("s2_n", 128'(n_samples), 128'(1));
    check_eq("s2_word", 128'(word_o[31:0]), 128'(32'h2C00_1ABC));
    check_eq("s2_strobe", 128'(word_valid), 128'(1));

    repeat (18) send_word(32'hD000_0000 | ($urandom & 32'h0FFF_FFFF));
    check_eq("frame_sat", 128'(frame_cnt), 128'(CMAX));

    send_word(32'h8300_0000);
    check_eq("s3_bln", 128'(word_type), 128'(2));
    check_eq("s3_n", 128'(n_samples), 128'(3));
    send_word(32'h8500_0000);
    check_eq("s3_err", 128'(word_type), 128'(9));
    check_eq("s3_errcnt", 128'(err_cnt), 128'(1));
    check_eq("s3_aligned", 128'(aligned), 128'(1));

    // Reset ten bits into a word, then relock.
    w = 32'hE000_0000;
    for (int b = WW - 1; b >= WW - 10; b--) step({3'($urandom), w[b]});
    rst = 1'b1;
    step({3'($urandom), 1'b0});
    check_eq("s6_valid", 128'(word_valid), 128'(0));
    check_eq("s6_outs", 128'({word_o, word_type, n_samples, frame_cnt, err_cnt}), 128'(0));
    rst = 1'b0;
    send_bits(3, 1'b0);
    send_word({8'h35, 24'($urandom)});
    check_eq("s6_relock", 128'(aligned), 128'(1));

    for (int i = 0; i < 4; i++) begin
      send_word(32'h0);
      check_eq("s4_aligned", 128'(aligned), 128'(i < 3));
    end
    check_eq("s4_errcnt", 128'(err_cnt), 128'(4));

    // ATM mode: raw words, every lane aligned to lane 0.
    test_enable = 1'b1;
    send_bits(4, 1'b0);
    send_word({8'h5A, 24'($urandom)});
    check_eq("s5_aligned", 128'(aligned), 128'(1));
    check_eq("s5_type", 128'(word_type), 128'(0));
    repeat (3) begin
      w = $urandom;
      send_word(w);
      check_eq("s5_lane0", 128'(word_o[31:0]), 128'(w));
      check_eq("s5_lane1", 128'(word_o[63:32]), 128'(last_lane1));
      check_eq("s5_raw", 128'(word_type), 128'(0));
    end

    test_enable = 1'b0;
    step({3'($urandom), 1'b0});
    check_eq("flip_aligned", 128'(aligned), 128'(0));
    check_eq("flip_valid", 128'(word_valid), 128'(0));
    send_bits(40, 1'b0);
    check_eq("flip_nostrobe", 128'(word_valid), 128'(0));

    cal_busy = 1'b1;
    send_word({8'h35, 24'($urandom)});
    check_eq("cal_lock", 128'(aligned), 128'(1));
    send_word(32'h0);
    check_eq("cal_raw", 128'(word_type), 128'(0));
    check_eq("cal_aligned", 128'(aligned), 128'(1));
    cal_busy = 1'b0;

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 10));
      cal_busy = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) test_enable = ~test_enable;
      if (kind >= 9) begin
        send_bits(int'($urandom_range(1, 40)), 1'b1);
      end else begin
        w = pre[kind] | ($urandom & msk[kind]);
        send_word(w);
      end
    end
    test_enable = 1'b0;
    cal_busy    = 1'b0;

    rst = 1'b1;
    step('0);
    rst = 1'b0;
    repeat (5) begin
      send_word({8'h35, 24'($urandom)});
      repeat (4) send_word(32'h0);
    end
    check_eq("err_sat", 128'(err_cnt), 128'(CMAX));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
